// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer: phase accumulator, quadrant fold and angle scaling ahead of an iterative CORDIC,
// plus result sign-correction and a timeout guard on the CORDIC handshake.
module cordic_phase_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic [7:0] ftw_i,
    input  logic       clear_flags_i,
    output logic [7:0] cordic_z_o,
    output logic       cordic_strobe_o,
    input  logic [7:0] cordic_x_i,
    input  logic       cordic_done_i,
    output logic [7:0] sample_o,
    output logic       sample_valid_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       timeout_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t        state, state_nxt;
    logic [7:0]    phase;
    logic          neg;
    logic [TW-1:0] timer;
    logic          fold, accept, expire;
    logic [7:0]    folded, mag, ang, z_new, x_neg;

    // Phases in 64..191 lie outside +-pi/2; reflect about pi/2 and negate the result.
    assign fold   = phase[7] ^ phase[6];
    assign folded = fold ? 8'd128 - phase : phase;
    assign mag    = folded[7] ? -folded : folded;
    assign ang    = mag + (mag >> 1) + (mag >> 4) + (mag >> 7);
    assign z_new  = folded[7] ? -ang : ang;
    assign x_neg  = (cordic_x_i == 8'h80) ? 8'h7f : -cordic_x_i;

    assign accept = (state == IDLE) && tick_i && enable_i;
    assign expire = (state == WAIT) && !cordic_done_i && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            phase      <= '0;
            neg        <= 1'b0;
            timer      <= '0;
            cordic_z_o <= '0;
            sample_o   <= '0;
            overrun_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                phase      <= phase + ftw_i;
                cordic_z_o <= z_new;
                neg        <= fold;
            end
            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + 1'b1;
            if (state == WAIT && cordic_done_i)
                sample_o <= neg ? x_neg : cordic_x_i;
            overrun_o <= (tick_i && enable_i && state != IDLE) || (overrun_o && !clear_flags_i);
            timeout_o <= expire || (timeout_o && !clear_flags_i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = cordic_done_i ? OUTPUT : (expire ? IDLE : WAIT);
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cordic_strobe_o = (state == ISSUE);
        sample_valid_o  = (state == OUTPUT);
        busy_o          = (state != IDLE);
    end
endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// tb_cordic_phase_sequencer: transaction-level reference model driving the sequencer with directed and random
// ticks, acting as the CORDIC responder with chosen latency or no answer.
module tb_cordic_phase_sequencer;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable_i = 1'b0, tick_i = 1'b0, clear_flags_i = 1'b0, cordic_done_i = 1'b0;
    logic [7:0] ftw_i = '0, cordic_x_i = '0;
    logic [7:0] cordic_z_o, sample_o;
    logic       cordic_strobe_o, sample_valid_o, busy_o, overrun_o, timeout_o;

    int n_total = 0;
    int n_bad   = 0;
    int mphase  = 0;
    int exp_sample = 0;

    cordic_phase_sequencer #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .tick_i(tick_i), .ftw_i(ftw_i),
        .clear_flags_i(clear_flags_i), .cordic_z_o(cordic_z_o), .cordic_strobe_o(cordic_strobe_o),
        .cordic_x_i(cordic_x_i), .cordic_done_i(cordic_done_i), .sample_o(sample_o),
        .sample_valid_o(sample_valid_o), .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Angle for phase p: fold into +-64 quarter-turn units, then scale by ~pi/2 into Q2.6.
    function automatic int ref_z(input int p);
        int q, m, a;
        q = (p >= 64 && p < 192) ? 128 - p : p;
        if (q > 127) q -= 256;
        m = q < 0 ? -q : q;
        a = m + m / 2 + m / 16 + m / 128;
        return q < 0 ? -a : a;
    endfunction

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick_i = 1'b0; cordic_done_i = 1'b0; clear_flags_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mphase = 0;
        exp_sample = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_z"}, int'(cordic_z_o), 0);
        check({tag, "_sample"}, int'(sample_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_strobe"}, int'(cordic_strobe_o), 0);
        check({tag, "_valid"}, int'(sample_valid_o), 0);
        check({tag, "_flags"}, int'({overrun_o, timeout_o}), 0);
    endtask

    // One accepted tick; lat = cycles from strobe to done (done lands at tick+lat+1).
    task automatic txn(input logic [7:0] ftw, input int lat, input logic [7:0] x, input bit answer, input bit intrude);
        int exp_z, n_valid, loops, xs;
        bit exp_neg;
        exp_z   = ref_z(mphase);
        exp_neg = (mphase >= 64 && mphase < 192);
        mphase  = (mphase + int'(ftw)) % 256;
        n_valid = 0;
        @(negedge clk);
        ftw_i = ftw; tick_i = 1'b1; enable_i = 1'b1; clear_flags_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0; clear_flags_i = 1'b0; cordic_x_i = 8'($urandom);
        check("strobe", int'(cordic_strobe_o), 1);
        check("z", sx(cordic_z_o), exp_z);
        check("busy_issue", int'(busy_o), 1);
        loops = answer ? lat : TO;
        for (int i = 0; i < loops; i++) begin
            @(negedge clk);
            n_valid += int'(sample_valid_o);
            tick_i = (intrude && i == 0);
            ftw_i  = 8'($urandom);
        end
        tick_i = 1'b0;
        if (answer) begin
            cordic_done_i = 1'b1; cordic_x_i = x;
            @(negedge clk);
            cordic_done_i = 1'b0;
            xs = sx(x);
            exp_sample = exp_neg ? (xs == -128 ? 127 : -xs) : xs;
            check("valid_pre", n_valid, 0);
            check("valid", int'(sample_valid_o), 1);
            check("sample", sx(sample_o), exp_sample);
            @(negedge clk);
            check("valid_once", int'(sample_valid_o), 0);
            check("busy_end", int'(busy_o), 0);
            check("timeout_clear", int'(timeout_o), 0);
        end else begin
            check("busy_last_wait", int'(busy_o), 1);
            check("timeout_early", int'(timeout_o), 0);
            @(negedge clk);
            check("valid_none", n_valid + int'(sample_valid_o), 0);
            check("timeout", int'(timeout_o), 1);
            check("busy_after_to", int'(busy_o), 0);
            check("sample_held", sx(sample_o), exp_sample);
        end
        check("overrun", int'(overrun_o), int'(intrude));
    endtask

    initial begin
        do_reset();
        check_idle_zero("reset");

        txn(8'd0, 5, 8'h4F, 1, 0);
        check("first_z", int'(cordic_z_o), 0);
        check("first_sample", int'(sample_o), 8'h4F);

        do_reset();
        txn(8'd96, 3, 8'h12, 1, 0);
        txn(8'd96, 4, 8'h40, 1, 0);
        check("fold_z", int'(cordic_z_o), 8'h32);
        check("fold_sample", int'(sample_o), 8'hC0);

        do_reset();
        txn(8'd224, 2, 8'h33, 1, 0);
        txn(8'd224, 2, 8'h5A, 1, 0);
        check("negz_z", int'(cordic_z_o), 8'hCE);
        check("negz_sample", int'(sample_o), 8'h5A);

        do_reset();
        txn(8'd64, 1, 8'h01, 1, 0);
        txn(8'd64, 6, 8'h80, 1, 0);
        check("p64_z", int'(cordic_z_o), 8'h64);
        check("sat_sample", int'(sample_o), 8'h7F);

        txn(8'd10, 3, 8'h20, 1, 1);
        @(negedge clk);
        clear_flags_i = 1'b1;
        @(negedge clk);
        clear_flags_i = 1'b0;
        check("overrun_cleared", int'(overrun_o), 0);
        txn(8'd5, 2, 8'h21, 1, 0);

        txn(8'd7, TO, 8'h6B, 1, 0);
        txn(8'd9, 0, 8'h00, 0, 0);

        @(negedge clk);
        enable_i = 1'b0; tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        check("dis_busy", int'(busy_o), 0);
        check("dis_overrun", int'(overrun_o), 0);
        enable_i = 1'b1;

        @(negedge clk);
        cordic_done_i = 1'b1; cordic_x_i = 8'h11;
        @(negedge clk);
        cordic_done_i = 1'b0;
        check("stray_done_valid", int'(sample_valid_o), 0);
        check("stray_done_sample", sx(sample_o), exp_sample);
        txn(8'd3, 2, 8'h44, 1, 0);

        @(negedge clk);
        ftw_i = 8'd37; tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mphase = 0; exp_sample = 0;
        check_idle_zero("midreset");
        txn(8'd50, 2, 8'h30, 1, 0);

        for (int k = 0; k < 40; k++) begin
            int lat;
            bit ans, intr;
            ans  = ($urandom_range(0, 7) != 0);
            intr = ($urandom_range(0, 3) == 0);
            lat  = $urandom_range(1, 8);
            if (intr && lat < 2) lat = 2;
            txn(8'($urandom), lat, 8'($urandom), ans, intr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
